syscall_halt_unit: RTL
======================

// Module: syscall_halt_unit
// PURPOSE
//  Consumes the datapath syscall flag and the $v0/$a0 register-file read ports.
//  Executes the syscall service: print-latch, pause-until-button, or halt.
//  Produces run_en to gate PC/register/memory updates, and the SyscallOut and
//  total_cycle values for the display block. Clocked by the CPU run clock.
// PARAMETERS
//  HALT_CODE   32'd10  $v0 value that stops the CPU until reset
//  PRINT_CODE  32'd34  $v0 value that latches $a0 into syscall_out
//  PAUSE_CODE  32'd50  $v0 value that stalls until a resume button press
//  CNT_W       32      width of total_cycle and print_count
// PORTS
//  clk           in   1      CPU run clock (clk_run)
//  rst           in   1      asynchronous, active-high reset
//  syscall       in   1      controller syscall decode for the current instruction
//  v0            in   32     register $v0 (regfile port a during syscall)
//  a0            in   32     register $a0 (regfile port b during syscall)
//  resume_btn    in   1      raw board button, asynchronous to clk
//  run_en        out  1      1 = current instruction commits (PC, regfile, DM writes)
//  halted        out  1      1 in HALT state
//  paused        out  1      1 in PAUSE state
//  syscall_out   out  32     last $a0 printed
//  total_cycle   out  CNT_W  number of committed instructions
//  print_count   out  CNT_W  number of print syscalls executed
// BEHAVIOUR
//  Reset (async, any time, including mid-PAUSE): state=RUN; syscall_out=0,
//   total_cycle=0, print_count=0; sync flops=0; halted=paused=0; run_en=1.
//  States: RUN, PAUSE, RESUME, HALT (2-bit encoded, registered).
//  stop_req = syscall & (v0==HALT_CODE | v0==PAUSE_CODE), combinational.
//  run_en (combinational):
//   RUN: ~stop_req.  RESUME: 1.  PAUSE, HALT: 0.
//   A halting or pausing syscall therefore does not advance the PC; it is the
//   instruction still held at the PC while stalled.
//  Transitions, on rising clk:
//   RUN, syscall & v0==HALT_CODE  -> HALT
//   RUN, syscall & v0==PAUSE_CODE -> PAUSE
//   PAUSE, resume_rise            -> RESUME
//   RESUME                        -> RUN (unconditional; syscall ignored, which
//                                    steps past the pausing syscall)
//   HALT                          -> HALT until rst
//   Any other condition holds the current state.
//  Print: in RUN with syscall & v0==PRINT_CODE, syscall_out<=a0 and
//   print_count+=1 on the same edge. The instruction commits (run_en=1).
//  Any other v0 value with syscall in RUN acts as a NOP: it commits and no
//   output changes except total_cycle.
//  total_cycle += 1 on each edge where run_en=1. Saturates at all-ones; no wrap.
//   print_count saturates the same way.
//  resume_btn: passes through a 2-flop synchronizer, then a rising-edge detect.
//   resume_rise lasts one clk.
//   A press seen outside PAUSE is discarded; it is not queued.
//   A held button gives exactly one resume.
//  Priority: rst > state transitions. HALT_CODE and PAUSE_CODE are mutually
//   exclusive by value. If they are equal, HALT wins.
//  Output latency: halted/paused assert 1 clk after the triggering syscall edge.
//   run_en drops in the same cycle as the triggering syscall.
// TESTING
//  1. Print: syscall=1, v0=34, a0=32'hDEADBEEF for 1 clk -> syscall_out=DEADBEEF,
//     print_count=1, run_en stays 1, total_cycle increments.
//  2. Halt: 5 plain cycles, then syscall, v0=10 -> run_en=0 in that cycle,
//     halted=1 next edge, total_cycle frozen at 5; 20 extra clks change nothing.
//  3. Pause/resume: syscall, v0=50 held -> paused=1, run_en=0; press resume_btn
//     for 10 clks -> run_en=1 for exactly 1 clk (RESUME), then RUN; one resume only.
//  4. Early press: resume_btn pulse while in RUN, then pause syscall -> remains
//     PAUSE until a new press.
//  5. Reset mid-PAUSE: assert rst asynchronously between edges -> run_en=1,
//     paused=0, counters=0 immediately, without waiting for a clk edge.
//  6. Saturation: force total_cycle=32'hFFFFFFFE, run 3 clks -> 32'hFFFFFFFF held.

Source files
------------

// File: rtl/syscall_halt_unit.sv
// Syscall service unit: print latch, pause-until-button, halt; gates instruction commit.
// Latency: run_en is combinational in the syscall cycle; halted/paused/counters update 1 clk later.
// Backpressure: run_en=0 stalls the CPU while a halt or pause is in effect; no upstream handshake.
module syscall_halt_unit #(
  parameter logic [31:0] HALT_CODE  = 32'd10,
  parameter logic [31:0] PRINT_CODE = 32'd34,
  parameter logic [31:0] PAUSE_CODE = 32'd50,
  parameter int          CNT_W      = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             syscall_i,
  input  logic [31:0]      v0_i,
  input  logic [31:0]      a0_i,
  input  logic             resume_btn_i,
  output logic             run_en_o,
  output logic             halted_o,
  output logic             paused_o,
  output logic [31:0]      syscall_out_o,
  output logic [CNT_W-1:0] total_cycle_o,
  output logic [CNT_W-1:0] print_count_o
);

  typedef enum logic [1:0] {
    S_RUN    = 2'd0,
    S_PAUSE  = 2'd1,
    S_RESUME = 2'd2,
    S_HALT   = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t            state_q, state_d;
  logic              btn_s1_q, btn_s2_q, btn_prev_q;
  logic [31:0]       syscall_out_q, syscall_out_d;
  logic [CNT_W-1:0]  total_cycle_q, total_cycle_d;
  logic [CNT_W-1:0]  print_count_q, print_count_d;

  logic is_halt, is_pause, is_print, stop_req, resume_rise, run_en;

  // Decode the service request; halt takes precedence if the codes ever coincide.
  always_comb begin
    is_halt     = syscall_i && (v0_i == HALT_CODE);
    is_pause    = syscall_i && (v0_i == PAUSE_CODE) && !is_halt;
    is_print    = syscall_i && (v0_i == PRINT_CODE) && !is_halt && !is_pause;
    stop_req    = is_halt || is_pause;
    resume_rise = btn_s2_q && !btn_prev_q;
  end

  // Next state, commit enable and counter/latch next values.
  always_comb begin
    state_d       = state_q;
    run_en        = 1'b1;
    syscall_out_d = syscall_out_q;
    print_count_d = print_count_q;
    total_cycle_d = total_cycle_q;
    case (state_q)
      S_RUN: begin
        run_en = !stop_req;
        if (is_halt) begin
          state_d = S_HALT;
        end else if (is_pause) begin
          state_d = S_PAUSE;
        end else if (is_print) begin
          syscall_out_d = a0_i;
          if (print_count_q != CNT_MAX) print_count_d = print_count_q + CNT_ONE;
        end
      end
      S_PAUSE: begin
        run_en = 1'b0;
        // Button edges outside PAUSE are simply dropped, never remembered.
        if (resume_rise) state_d = S_RESUME;
      end
      S_RESUME: begin
        // Commit the stalled pause syscall so the PC steps past it.
        run_en  = 1'b1;
        state_d = S_RUN;
      end
      S_HALT: begin
        run_en = 1'b0;
      end
      default: begin
        run_en  = 1'b0;
        state_d = S_HALT;
      end
    endcase
    if (run_en && (total_cycle_q != CNT_MAX)) total_cycle_d = total_cycle_q + CNT_ONE;
  end

  // State, latch and counter registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= S_RUN;
      syscall_out_q <= 32'd0;
      total_cycle_q <= '0;
      print_count_q <= '0;
    end else begin
      state_q       <= state_d;
      syscall_out_q <= syscall_out_d;
      total_cycle_q <= total_cycle_d;
      print_count_q <= print_count_d;
    end
  end

  // Two-flop synchronizer for the raw button plus one delay flop for edge detection.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      btn_s1_q   <= 1'b0;
      btn_s2_q   <= 1'b0;
      btn_prev_q <= 1'b0;
    end else begin
      btn_s1_q   <= resume_btn_i;
      btn_s2_q   <= btn_s1_q;
      btn_prev_q <= btn_s2_q;
    end
  end

  assign run_en_o      = run_en;
  assign halted_o      = (state_q == S_HALT);
  assign paused_o      = (state_q == S_PAUSE);
  assign syscall_out_o = syscall_out_q;
  assign total_cycle_o = total_cycle_q;
  assign print_count_o = print_count_q;

endmodule
